// File: rtl/ifu_pkg.sv
// ifu_pkg: pipeline types shared by the fetch unit and the decoder.
package ifu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] curr_pc;
        logic [XLEN-1:0] next_pc;
    } decode_signals;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
    } imem_req_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with flush and occupancy count.
// Used by ifu only when IFU_SKID_BUF_EN is defined.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = decode_signals
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  T                             din,
    output T                             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T mem [DEPTH];
    logic [AW-1:0] rd, wr;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign dout = mem[rd];

    always_ff @(posedge clk)
        if (push && !flush) mem[wr] <= din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= inc(wr);
            if (pop) rd <= inc(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit; owns the PC, fetches in order and hands words to decode.
// IFU_SKID_BUF_EN adds a 2-entry skid FIFO allowing 2 outstanding fetches (1 instr/cycle).
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decode_signals   signals_out
);
    logic            run, credit, grant, resp, accept, take, nxt_valid, load;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcq [2];
    logic [1:0]      outstanding, discard;
    decode_signals   word, nxt_sig;
    imem_req_t       fetch;

    // run delays the first request to the cycle after reset release
    assign fetch     = '{req: run && credit && !redirect, addr: pc};
    assign imem_req  = fetch.req;
    assign imem_addr = fetch.addr;

    // responses with nothing outstanding (stale after reset) are ignored
    assign grant  = imem_req && imem_gnt;
    assign resp   = imem_rvalid && outstanding != 2'd0;
    assign accept = resp && discard == 2'd0 && !redirect;
    assign take   = !out_valid || out_ready;
    assign word   = '{instr: imem_rdata, curr_pc: pcq[0], next_pc: pcq[0] + XLEN'(4)};

`ifdef IFU_SKID_BUF_EN
    logic [1:0]    fifo_count;
    logic          fifo_push, fifo_pop;
    decode_signals fifo_head;

    // words bypass the FIFO when it is empty and the output register is free
    assign credit    = outstanding + fifo_count < 2'd2;
    assign fifo_pop  = take && fifo_count != 2'd0;
    assign fifo_push = accept && !(take && fifo_count == 2'd0);
    assign nxt_valid = take ? (fifo_count != 2'd0 || accept) : 1'b1;
    assign nxt_sig   = fifo_count != 2'd0 ? fifo_head : word;
    assign load      = take && nxt_valid;

    ifu_fifo #(.DEPTH(2), .T(decode_signals)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (word),
        .dout    (fifo_head),
        .count   (fifo_count)
    );
`else
    assign credit    = outstanding == 2'd0 && take;
    assign nxt_valid = accept || !take;
    assign nxt_sig   = word;
    assign load      = accept;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            out_valid   <= 1'b0;
            signals_out <= '0;
            pcq[0]      <= '0;
            pcq[1]      <= '0;
        end else begin
            run         <= 1'b1;
            pc          <= redirect ? (redirect_pc & ~XLEN'(3)) : grant ? pc + XLEN'(4) : pc;
            outstanding <= outstanding + {1'b0, grant} - {1'b0, resp};
            // every fetch still in flight after a redirect belongs to the wrong path
            discard     <= redirect ? outstanding - {1'b0, resp} :
                           (resp && discard != 2'd0) ? discard - 2'd1 : discard;
            out_valid   <= !redirect && nxt_valid;
            if (load) signals_out <= nxt_sig;
            if (resp) pcq[0] <= pcq[1];
            // a grant implies at most one fetch already in flight
            if (grant) pcq[outstanding[0] & ~resp] <= pc;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for ifu against a PC-stream reference model.
// Works with or without IFU_SKID_BUF_EN.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] RPC = 32'h100;
`ifdef IFU_SKID_BUF_EN
    localparam int MAXO = 2;
    localparam int TPUT = 8;
`else
    localparam int MAXO = 1;
    localparam int TPUT = 4;
`endif

    logic          clk, reset_n, imem_req, imem_gnt, imem_rvalid, redirect, out_valid, out_ready;
    logic [31:0]   imem_addr, imem_rdata, redirect_pc;
    decode_signals signals_out;

    ifu #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .signals_out (signals_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t         pend[$];
    logic [31:0]   exp_q[$];
    int            n_checks = 0, n_fail = 0, cyc = 0, xfer_cnt = 0, x0;
    int            p_gnt, p_ready, p_redir, max_lat;
    bit            need_first, pv_req, pv_gnt, pv_valid, pv_ready, pv_redir;
    logic [31:0]   pv_addr, e;
    decode_signals pv_sig;

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // expected delivery order: consecutive words from the current stream start
    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic step(input bit force_redir, input logic [31:0] tgt);
        logic [31:0] t;
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ifn(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = int'($urandom_range(99)) < p_gnt;
        if (force_redir || exp_q.size() < 16 || int'($urandom_range(999)) < p_redir) begin
            t = force_redir ? tgt : ($urandom_range(3) == 0 ? {28'hFFFF_FFF, 4'($urandom)} : $urandom);
            redirect    = 1'b1;
            redirect_pc = t;
            out_ready   = 1'b0;
            refill(t & ~32'h3);
        end else begin
            redirect  = 1'b0;
            out_ready = int'($urandom_range(99)) < p_ready;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        out_ready   = 1'b0;
        pend.delete();
        refill(RPC);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // memory: records granted fetches and schedules in-order responses
    initial forever begin
        @(negedge clk);
        if (reset_n && imem_req && imem_gnt) begin
            pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(max_lat, 1))});
            chk(pend.size() <= MAXO, "outstanding_max", 32'(pend.size()), 32'(MAXO));
        end
    end

    // monitor: protocol checks and scoreboard pops on each transfer
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            chk(!out_valid, "rst_out_valid", 32'(out_valid), 32'd0);
            chk(signals_out == '0, "rst_signals", signals_out.curr_pc, 32'd0);
            chk(!imem_req, "rst_req", 32'(imem_req), 32'd0);
            need_first = 1'b1;
            pv_req     = 1'b0;
            pv_valid   = 1'b0;
            pv_redir   = 1'b0;
        end else begin
            if (imem_req) chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & ~32'h3);
            if (imem_req && need_first) chk(imem_addr == RPC, "first_req_addr", imem_addr, RPC);
            if (imem_req || redirect) need_first = 1'b0;
            if (redirect) chk(!imem_req, "req_in_redirect", 32'(imem_req), 32'd0);
            if (pv_req && !pv_gnt && !redirect)
                chk(imem_req && imem_addr == pv_addr, "req_hold", imem_addr, pv_addr);
            if (pv_redir) chk(!out_valid, "valid_after_redirect", 32'(out_valid), 32'd0);
            if (pv_valid && !pv_ready && !pv_redir)
                chk(out_valid && signals_out == pv_sig, "out_hold", signals_out.curr_pc, pv_sig.curr_pc);
`ifndef IFU_SKID_BUF_EN
            if (out_valid && !out_ready) chk(!imem_req, "req_under_backpressure", 32'(imem_req), 32'd0);
`endif
            if (out_valid && out_ready) begin
                xfer_cnt++;
                chk(exp_q.size() != 0, "exp_available", signals_out.curr_pc, 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(signals_out.curr_pc == e, "curr_pc", signals_out.curr_pc, e);
                    chk(signals_out.next_pc == e + 32'd4, "next_pc", signals_out.next_pc, e + 32'd4);
                    chk(signals_out.instr == ifn(e), "instr", signals_out.instr, ifn(e));
                end
            end
            pv_req   = imem_req;
            pv_gnt   = imem_gnt;
            pv_addr  = imem_addr;
            pv_valid = out_valid;
            pv_ready = out_ready;
            pv_redir = redirect;
            pv_sig   = signals_out;
        end
    end

    initial begin
        reset_n     = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        p_gnt = 100; p_ready = 100; p_redir = 0; max_lat = 1;
        do_reset();
        // zero-wait memory, decode always ready
        repeat (12) step(1'b0, '0);
        x0 = xfer_cnt;
        repeat (8) step(1'b0, '0);
        chk(xfer_cnt - x0 == TPUT, "throughput_8_cycles", 32'(xfer_cnt - x0), 32'(TPUT));
        // backpressure
        p_ready = 0;
        repeat (6) step(1'b0, '0);
        p_ready = 100;
        repeat (6) step(1'b0, '0);
        // redirects with fetches in flight, then across the address wrap
        max_lat = 3;
        repeat (4) step(1'b0, '0);
        step(1'b1, 32'h203);
        repeat (20) step(1'b0, '0);
        step(1'b1, 32'hFFFF_FFF8);
        repeat (20) step(1'b0, '0);
        // random traffic, mid-run reset, more random traffic
        p_gnt = 60; p_ready = 70; p_redir = 30; max_lat = 4;
        repeat (3000) step(1'b0, '0);
        do_reset();
        repeat (1500) step(1'b0, '0);
        chk(xfer_cnt > 300, "progress", 32'(xfer_cnt), 32'd300);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
